// File: rtl/pipe_mips32_pkg.sv
// Shared types and constants for the pipe_mips32 core.
// MUL_EN: when defined, opcode 000101 decodes as MUL. Otherwise it is a NOP.
package pipe_mips32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned OPW   = 6;

  // Instruction field slices
  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_AND   = 6'b000010;
  localparam logic [OPW-1:0] OP_OR    = 6'b000011;
  localparam logic [OPW-1:0] OP_SLT   = 6'b000100;
  localparam logic [OPW-1:0] OP_MUL   = 6'b000101;
  localparam logic [OPW-1:0] OP_LW    = 6'b001000;
  localparam logic [OPW-1:0] OP_SW    = 6'b001001;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001010;
  localparam logic [OPW-1:0] OP_SUBI  = 6'b001011;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001100;
  localparam logic [OPW-1:0] OP_BNEQZ = 6'b001101;
  localparam logic [OPW-1:0] OP_BEQZ  = 6'b001110;
  localparam logic [OPW-1:0] OP_HLT   = 6'b111111;

  // Unassigned opcode, used as the idle instruction word in IF/ID
  localparam logic [XLEN-1:0] NOP_IR = 32'hF800_0000;

  // NOP first so an all-zero pipeline register is a bubble
  typedef enum logic [2:0] {
    NOP, RR_ALU, RI_ALU, LOAD, STORE, BRANCH, HALT
  } itype_e;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
  } if_id_t;

  typedef struct packed {
    itype_e          itype;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   dst;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] npc;
  } id_ex_t;

  typedef struct packed {
    itype_e          itype;
    logic [RW-1:0]   dst;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] b;
    logic            cond;
  } ex_mem_t;

  typedef struct packed {
    itype_e          itype;
    logic [RW-1:0]   dst;
    logic [XLEN-1:0] wdata;
  } mem_wb_t;

  // Opcode to instruction class
  function automatic itype_e decode(input logic [OPW-1:0] op);
    itype_e t;
    t = NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: t = RR_ALU;
`ifdef MUL_EN
      OP_MUL:                                t = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             t = RI_ALU;
      OP_LW:                                 t = LOAD;
      OP_SW:                                 t = STORE;
      OP_BNEQZ, OP_BEQZ:                     t = BRANCH;
      OP_HLT:                                t = HALT;
      default:                               t = NOP;
    endcase
    return t;
  endfunction

  // Classes that write the register file at WB
  function automatic logic writes_reg(input itype_e t);
    return (t == RR_ALU) || (t == RI_ALU) || (t == LOAD);
  endfunction

endpackage

// File: rtl/pipe_mips32_alu.sv
// Combinational ALU; address and branch-target adds share the adder.
// MUL_EN: when defined, a 32x32 multiplier (low half) is built.
module pipe_mips32_alu
  import pipe_mips32_pkg::*;
(
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c
);

  // Result select by opcode
  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BNEQZ, OP_BEQZ: result_c = a + b;
      OP_SUB, OP_SUBI:                                  result_c = a - b;
      OP_AND:                                           result_c = a & b;
      OP_OR:                                            result_c = a | b;
      OP_SLT, OP_SLTI: result_c = {31'b0, ($signed(a) < $signed(b))};
`ifdef MUL_EN
      OP_MUL:                                           result_c = XLEN'(a * b);
`else
      OP_MUL:                                           result_c = '0;
`endif
      default:                                          result_c = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// 5-stage in-order MIPS-like core with unified word-addressed memory.
// Branches resolve in EX and redirect fetch from EX/MEM (2-cycle penalty).
// MUL_EN: when defined, MUL is implemented; otherwise opcode 000101 is a NOP.
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
)(
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] Reg [0:NREGS-1];
  logic [XLEN-1:0] mem [0:MEM_DEPTH-1];
  logic [XLEN-1:0] pc;
  logic            taken_branch;

  if_id_t  if_id;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  id_ex_t          id_nxt_c;
  ex_mem_t         ex_nxt_c;
  mem_wb_t         wb_nxt_c;
  logic [RW-1:0]   rs_c, rt_c, rd_c;
  logic [XLEN-1:0] op_a_c, op_b_c;
  logic [XLEN-1:0] mem_rd_c, ex_fwd_c;
  logic [XLEN-1:0] alu_a_c, alu_b_c, alu_y_c;
  logic            take_c, frz_c;

  assign frz_c  = halted || (mem_wb.itype == HALT);
  assign take_c = (ex_mem.itype == BRANCH) && ex_mem.cond;

  // Data read for the MEM stage, also the load-forward value from EX/MEM
  assign mem_rd_c = mem[ex_mem.aluout[AW-1:0]];
  assign ex_fwd_c = (ex_mem.itype == LOAD) ? mem_rd_c : ex_mem.aluout;

  assign rs_c = if_id.ir[RS_HI:RS_LO];
  assign rt_c = if_id.ir[RT_HI:RT_LO];
  assign rd_c = if_id.ir[RD_HI:RD_LO];

  // ID operand read with bypass; later overrides give EX/MEM highest priority
  always_comb begin
    op_a_c = Reg[rs_c];
    op_b_c = Reg[rt_c];
    if (writes_reg(mem_wb.itype) && mem_wb.dst == rs_c) op_a_c = mem_wb.wdata;
    if (writes_reg(mem_wb.itype) && mem_wb.dst == rt_c) op_b_c = mem_wb.wdata;
    if (writes_reg(ex_mem.itype) && ex_mem.dst == rs_c) op_a_c = ex_fwd_c;
    if (writes_reg(ex_mem.itype) && ex_mem.dst == rt_c) op_b_c = ex_fwd_c;
    if (rs_c == '0) op_a_c = '0;
    if (rt_c == '0) op_b_c = '0;
  end

  // Decode of the instruction in IF/ID
  always_comb begin
    id_nxt_c       = '0;
    id_nxt_c.itype = decode(if_id.ir[OP_HI:OP_LO]);
    id_nxt_c.op    = if_id.ir[OP_HI:OP_LO];
    id_nxt_c.dst   = (id_nxt_c.itype == RR_ALU) ? rd_c : rt_c;
    id_nxt_c.a     = op_a_c;
    id_nxt_c.b     = op_b_c;
    id_nxt_c.imm   = {{16{if_id.ir[IMM_HI]}}, if_id.ir[IMM_HI:IMM_LO]};
    id_nxt_c.npc   = if_id.npc;
  end

  // EX operand select: branches add the offset to the next pc
  always_comb begin
    alu_a_c = (id_ex.itype == BRANCH) ? id_ex.npc : id_ex.a;
    alu_b_c = (id_ex.itype == RR_ALU) ? id_ex.b : id_ex.imm;
  end

  pipe_mips32_alu u_alu (
    .op       (id_ex.op),
    .a        (alu_a_c),
    .b        (alu_b_c),
    .result_c (alu_y_c)
  );

  // EX/MEM and MEM/WB next values
  always_comb begin
    ex_nxt_c        = '0;
    ex_nxt_c.itype  = id_ex.itype;
    ex_nxt_c.dst    = id_ex.dst;
    ex_nxt_c.aluout = alu_y_c;
    ex_nxt_c.b      = id_ex.b;
    ex_nxt_c.cond   = (id_ex.itype == BRANCH) &&
                      ((id_ex.op == OP_BEQZ) ? (id_ex.a == '0) : (id_ex.a != '0));
    wb_nxt_c        = '0;
    wb_nxt_c.itype  = ex_mem.itype;
    wb_nxt_c.dst    = ex_mem.dst;
    wb_nxt_c.wdata  = (ex_mem.itype == LOAD) ? mem_rd_c : ex_mem.aluout;
  end

  // Pipeline advance, branch redirect with squash, and halt freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      halted       <= 1'b0;
      taken_branch <= 1'b0;
      if_id.ir     <= NOP_IR;
      if_id.npc    <= '0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
    end else begin
      taken_branch <= take_c && !frz_c;
      if (mem_wb.itype == HALT) halted <= 1'b1;
      if (!frz_c) begin
        if (take_c) begin
          if_id.ir  <= mem[ex_mem.aluout[AW-1:0]];
          if_id.npc <= ex_mem.aluout + 32'd1;
          pc        <= ex_mem.aluout + 32'd1;
          id_ex     <= '0;
          ex_mem    <= '0;
        end else begin
          if_id.ir  <= mem[pc[AW-1:0]];
          if_id.npc <= pc + 32'd1;
          pc        <= pc + 32'd1;
          id_ex     <= id_nxt_c;
          ex_mem    <= ex_nxt_c;
        end
        mem_wb <= wb_nxt_c;
      end
    end
  end

  // Register file write at WB; R0 stays zero
  always_ff @(posedge clk) begin
    if (!halted && writes_reg(mem_wb.itype) && mem_wb.dst != '0)
      Reg[mem_wb.dst] <= mem_wb.wdata;
  end

  // Store write at MEM, blocked once HLT reaches WB
  always_ff @(posedge clk) begin
    if (!frz_c && ex_mem.itype == STORE)
      mem[ex_mem.aluout[AW-1:0]] <= ex_mem.b;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program tests for pipe_mips32 with hand-computed results.
module tb_pipe_mips32;

  localparam logic [5:0] ADD = 6'b000000, OR_ = 6'b000011, MUL = 6'b000101;
  localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;
  localparam logic [31:0] IDLE_W = 32'hF800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  int total = 0;
  int bad = 0;
  int ntaken;
  int cyc;
  logic [31:0] prog[$];

  pipe_mips32 dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%08h) exp=%0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Hold reset, load prog[] at address 0 and preload Reg[k]=k
  task automatic load_prog();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.mem[i] = IDLE_W;
    for (int i = 0; i < prog.size(); i++) dut.mem[i] = prog[i];
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    ntaken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (dut.taken_branch) ntaken++;
  endtask

  // Run until halted with a cycle budget; returns cycles stepped
  task automatic run_halt(input int maxc, output int n);
    n = 0;
    while (!halted && n < maxc) begin
      step();
      n++;
    end
    check("halt_seen", 32'(halted), 32'd1);
  endtask

  logic [31:0] fact_r2, fact_addr;

  initial begin
    #1 rst_n = 1'b0;

    // ---- T1: forwarding paths and latency ----
    prog = '{ri(ADDI,1,0,10), ri(ADDI,2,0,20), ri(ADDI,3,0,25),
             rr(OR_,7,7,7), rr(OR_,7,7,7), rr(ADD,4,1,2), rr(OR_,7,7,7),
             rr(ADD,5,4,3), HLT_W};
    load_prog();
    check("rst_pc", dut.pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_taken", 32'(dut.taken_branch), 32'd0);
    release_rst();
    repeat (4) step();
    check("lat_before_wb", dut.Reg[1], 32'd1);
    step();
    check("lat_at_wb", dut.Reg[1], 32'd10);
    run_halt(100, cyc);
    check("t1_halt_cycle", 32'(cyc + 5), 32'd13);
    check("t1_r1", dut.Reg[1], 32'd10);
    check("t1_r2", dut.Reg[2], 32'd20);
    check("t1_r3", dut.Reg[3], 32'd25);
    check("t1_r4", dut.Reg[4], 32'd30);
    check("t1_r5", dut.Reg[5], 32'd55);

    // ---- T2: load/store with load forwarding ----
    prog = '{ri(ADDI,1,0,120), rr(OR_,7,7,7), ri(LW,2,1,0), rr(OR_,7,7,7),
             ri(ADDI,2,2,45), rr(OR_,7,7,7), ri(SW,2,1,1), HLT_W};
    load_prog();
    dut.mem[120] = 32'd100;
    dut.mem[121] = 32'd0;
    release_rst();
    run_halt(100, cyc);
    check("t2_mem121", dut.mem[121], 32'd145);
    check("t2_r2", dut.Reg[2], 32'd145);

    // ---- T3: factorial loop (MUL is a NOP without MUL_EN) ----
`ifdef MUL_EN
    fact_r2 = 32'd24; fact_addr = 32'd22;
`else
    fact_r2 = 32'd1;  fact_addr = 32'd1023;
`endif
    prog = '{ri(ADDI,10,0,200), ri(ADDI,2,0,1), rr(OR_,20,20,20), ri(LW,3,10,0),
             rr(OR_,20,20,20), rr(MUL,2,2,3), ri(SUBI,3,3,1), rr(OR_,20,20,20),
             ri(BNEQZ,0,3,-4), ri(SW,2,2,-2), HLT_W};
    load_prog();
    dut.mem[200] = 32'd4;
    dut.mem[fact_addr[9:0]] = 32'd0;
    release_rst();
    run_halt(300, cyc);
    check("t3_r2", dut.Reg[2], fact_r2);
    check("t3_r3", dut.Reg[3], 32'd0);
    check("t3_mem", dut.mem[fact_addr[9:0]], fact_r2);
    check("t3_taken_cnt", 32'(ntaken), 32'd3);

    // ---- T4: reset in the middle of the loop, then rerun ----
    load_prog();
    dut.mem[200] = 32'd4;
    dut.mem[fact_addr[9:0]] = 32'd0;
    release_rst();
    repeat (12) step();
    check("t4_taken_pre", 32'(dut.taken_branch), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_pc", dut.pc, 32'd0);
    check("t4_rst_halted", 32'(halted), 32'd0);
    check("t4_rst_taken", 32'(dut.taken_branch), 32'd0);
    check("t4_reg_kept", dut.Reg[10], 32'd200);
    @(negedge clk);
    release_rst();
    run_halt(300, cyc);
    check("t4_r2", dut.Reg[2], fact_r2);
    check("t4_r3", dut.Reg[3], 32'd0);
    check("t4_mem", dut.mem[fact_addr[9:0]], fact_r2);

    // ---- T5: taken BEQZ squash, instruction after HLT, freeze ----
    prog = '{ri(BEQZ,0,0,2), ri(ADDI,5,0,7), ri(ADDI,6,0,9), ri(ADDI,8,0,33),
             HLT_W, ri(ADDI,7,0,1)};
    load_prog();
    release_rst();
    run_halt(100, cyc);
    check("t5_halt_cycle", 32'(cyc), 32'd9);
    check("t5_r5", dut.Reg[5], 32'd5);
    check("t5_r6", dut.Reg[6], 32'd6);
    check("t5_r8", dut.Reg[8], 32'd33);
    check("t5_taken_cnt", 32'(ntaken), 32'd1);
    repeat (10) step();
    check("t5_pc_frozen", dut.pc, 32'd8);
    check("t5_r7", dut.Reg[7], 32'd7);
    check("t5_still_halted", 32'(halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
